// File: rtl/stream_mem_responder.sv
// stream_mem_responder
//   Word-addressed memory that answers a valid/ready request stream. Each accepted
//   request produces exactly one response pulse Latency cycles later. Responses have
//   no ready and are never stalled. The block also serves as a bench memory with
//   programmable latency and injectable backpressure.
//
// Ports
//   clk_i         clock
//   rst_ni        synchronous reset, active low
//   stall_i       1 = refuse requests this cycle
//   req_valid_i   request valid
//   req_ready_o   request accepted when valid & ready
//   req_addr_i    word address (>= NumWords is out of range)
//   req_we_i      1 = write, 0 = read
//   req_wdata_i   write data
//   req_strb_i    byte write enables
//   resp_valid_o  one pulse per accepted request
//   resp_rdata_o  read data; zero for writes, errors and idle cycles
//   resp_err_o    request address was out of range
//   num_reads_o   accepted reads, saturating
//   num_writes_o  accepted writes, saturating
module stream_mem_responder #(
  parameter int unsigned NumWords  = 32'd256,
  parameter int unsigned DataWidth = 32'd32,
  parameter int unsigned AddrWidth = 32'd8,
  parameter int unsigned Latency   = 32'd1,
  parameter int unsigned CntWidth  = 32'd16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_we_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  output logic                   resp_valid_o,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic                   resp_err_o,
  output logic [CntWidth-1:0]    num_reads_o,
  output logic [CntWidth-1:0]    num_writes_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [CntWidth-1:0] CntMax = '1;

  logic [DataWidth-1:0] mem [NumWords];

  logic                 accept;
  logic                 in_range;
  logic [DataWidth-1:0] rdata_now;
  logic                 err_now;

  // Ready is purely a function of reset and stall, so a request held across a
  // stall window is accepted exactly once, on the first cycle ready returns.
  assign req_ready_o = rst_ni & ~stall_i;
  assign accept      = req_valid_i & req_ready_o;
  assign in_range    = 64'(req_addr_i) < 64'(NumWords);

  // Response payload as seen in the accept cycle. Reads sample the array before
  // this edge's write lands, so an in-flight read is immune to later writes.
  always_comb begin
    rdata_now = '0;
    err_now   = 1'b0;
    if (accept) begin
      if (!in_range) begin
        err_now = 1'b1;
      end else if (!req_we_i) begin
        rdata_now = mem[req_addr_i];
      end
    end
  end

  // Byte-masked write; storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_we_i && in_range) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (req_strb_i[b]) begin
          mem[req_addr_i][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Saturating statistics counters; out-of-range accepts count too.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      num_reads_o  <= '0;
      num_writes_o <= '0;
    end else if (accept) begin
      if (req_we_i) begin
        if (num_writes_o != CntMax) num_writes_o <= num_writes_o + CntWidth'(1);
      end else begin
        if (num_reads_o != CntMax) num_reads_o <= num_reads_o + CntWidth'(1);
      end
    end
  end

  generate
    if (Latency == 0) begin : g_comb
      // Zero latency: the response is the accept cycle itself, nothing registered.
      assign resp_valid_o = accept;
      assign resp_rdata_o = rdata_now;
      assign resp_err_o   = err_now;
    end else begin : g_pipe
      logic [Latency-1:0]   pipe_valid;
      logic [Latency-1:0]   pipe_err;
      logic [DataWidth-1:0] pipe_rdata [Latency];

      // Fixed-depth shift register. Payload is already zero on idle cycles, so
      // the outputs read zero whenever the valid bit is low. Reset flushes every
      // stage, dropping in-flight responses.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          pipe_valid <= '0;
          pipe_err   <= '0;
          for (int i = 0; i < Latency; i++) pipe_rdata[i] <= '0;
        end else begin
          pipe_valid[0] <= accept;
          pipe_err[0]   <= err_now;
          pipe_rdata[0] <= rdata_now;
          for (int i = 1; i < Latency; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_rdata[i] <= pipe_rdata[i-1];
          end
        end
      end

      assign resp_valid_o = pipe_valid[Latency-1];
      assign resp_err_o   = pipe_err[Latency-1];
      assign resp_rdata_o = pipe_rdata[Latency-1];
    end
  endgenerate

  // Simulation-only sanity checks on the parameter set and the zero-latency path.
  always @(posedge clk_i) begin
    assert (DataWidth % 8 == 0);
    assert ((64'(NumWords) - 64'd1) < (64'd1 << AddrWidth));
    if (Latency == 0) assert (resp_valid_o == accept);
  end

endmodule
